// File: rtl/flag_branch_unit_pkg.sv
// ============================================================================
// Module   : flag_branch_unit_pkg
// Brief    : Shared types and constants for the flag/branch resolution unit.
// Revision : 1.0
// ============================================================================
`default_nettype none

package flag_branch_unit_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_XOR = 3'd2,
        OP_RED = 3'd3,
        OP_SLL = 3'd4,
        OP_SRA = 3'd5,
        OP_ROR = 3'd6,
        OP_PAD = 3'd7
    } opcode_t;

    typedef enum logic [2:0] {
        COND_NE  = 3'd0,
        COND_EQ  = 3'd1,
        COND_GT  = 3'd2,
        COND_LT  = 3'd3,
        COND_GE  = 3'd4,
        COND_LE  = 3'd5,
        COND_OV  = 3'd6,
        COND_UNC = 3'd7
    } br_cond_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } br_state_t;

    localparam int c_FLAG_Z = 2;
    localparam int c_FLAG_V = 1;
    localparam int c_FLAG_N = 0;

    // Only the arithmetic ops produce meaningful overflow/sign information.
    function automatic logic writes_vn(input opcode_t op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

`default_nettype wire

// File: rtl/flag_branch_unit_if.sv
// ============================================================================
// Module   : flag_branch_unit_if
// Brief    : ALU-retire, issue and branch request/response signal bundle.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface flag_branch_unit_if;
    logic        flag_issue;
    logic        issue_ready;
    logic        alu_valid;
    logic [2:0]  alu_opcode;
    logic [2:0]  alu_flags;
    logic        br_valid;
    logic        br_ready;
    logic [2:0]  br_cond;
    logic [15:0] br_target;
    logic [15:0] br_pc_plus2;
    logic        flush;
    logic        resp_valid;
    logic        resp_taken;
    logic [15:0] resp_next_pc;
    logic [2:0]  flags;
    logic        err_underflow;

    modport master (
        output flag_issue, alu_valid, alu_opcode, alu_flags,
               br_valid, br_cond, br_target, br_pc_plus2, flush,
        input  issue_ready, br_ready, resp_valid, resp_taken,
               resp_next_pc, flags, err_underflow
    );

    modport slave (
        input  flag_issue, alu_valid, alu_opcode, alu_flags,
               br_valid, br_cond, br_target, br_pc_plus2, flush,
        output issue_ready, br_ready, resp_valid, resp_taken,
               resp_next_pc, flags, err_underflow
    );
endinterface

`default_nettype wire

// File: rtl/flag_branch_unit_branch_cond_eval.sv
// ============================================================================
// Module   : branch_cond_eval
// Brief    : Combinational condition-code evaluation against {Z,V,N}.
// Revision : 1.0
// ============================================================================
`default_nettype none

module branch_cond_eval
    import flag_branch_unit_pkg::*;
(
    input  wire [2:0] i_cond,
    input  wire [2:0] i_flags,
    output logic      o_taken
);

    br_cond_t w_cond;
    logic     w_z;
    logic     w_v;
    logic     w_n;

    assign w_cond = br_cond_t'(i_cond);
    assign w_z    = i_flags[c_FLAG_Z];
    assign w_v    = i_flags[c_FLAG_V];
    assign w_n    = i_flags[c_FLAG_N];

    always_comb begin
        o_taken = 1'b0;
        case (w_cond)
            COND_NE:  o_taken = !w_z;
            COND_EQ:  o_taken = w_z;
            COND_GT:  o_taken = !w_z && !w_n;
            COND_LT:  o_taken = w_n;
            COND_GE:  o_taken = w_z || !w_n;
            COND_LE:  o_taken = w_z || w_n;
            COND_OV:  o_taken = w_v;
            COND_UNC: o_taken = 1'b1;
            default:  o_taken = 1'b0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/flag_branch_unit.sv
// ============================================================================
// Module   : flag_branch_unit
// Brief    : Flag register, in-flight writer counter and branch resolution FSM.
// Revision : 1.0
// ============================================================================
`default_nettype none

module flag_branch_unit
    import flag_branch_unit_pkg::*;
#(
    parameter int PEND_W = 2
)
(
    input  wire                clk,
    input  wire                rst,
    flag_branch_unit_if.slave  bus
);

    localparam logic [PEND_W-1:0] c_CNT_MAX = '1;
    localparam logic [PEND_W-1:0] c_CNT_ONE = PEND_W'(1);

    logic [PEND_W-1:0] r_count;
    logic [2:0]        r_flags;
    logic              r_err_underflow;
    br_state_t         r_state;
    br_state_t         w_state_nxt;
    logic [2:0]        r_cond;
    logic [15:0]       r_target;
    logic [15:0]       r_pc_plus2;
    logic              r_resp_taken;
    logic [15:0]       r_resp_next_pc;
    logic              w_issue_acc;
    logic              w_cnt_zero;
    logic              w_br_accept;
    logic              w_eval;
    logic              w_taken;
    logic              w_issue_ready;

    assign w_cnt_zero    = (r_count == '0);
    assign w_issue_ready = (r_count != c_CNT_MAX);
    assign w_issue_acc   = bus.flag_issue && w_issue_ready;

    // Retire at count 0 is an orphan: flag it but never wrap the counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (w_issue_acc && !bus.alu_valid) begin
            r_count <= r_count + c_CNT_ONE;
        end else if (!w_issue_acc && bus.alu_valid && !w_cnt_zero) begin
            r_count <= r_count - c_CNT_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_flags         <= 3'b000;
            r_err_underflow <= 1'b0;
        end else if (bus.alu_valid) begin
            r_flags[c_FLAG_Z] <= bus.alu_flags[c_FLAG_Z];
            if (writes_vn(opcode_t'(bus.alu_opcode))) begin
                r_flags[c_FLAG_V] <= bus.alu_flags[c_FLAG_V];
                r_flags[c_FLAG_N] <= bus.alu_flags[c_FLAG_N];
            end
            if (w_cnt_zero) begin
                r_err_underflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Evaluation waits for a quiet retire port so it never races a flag write.
    always_comb begin
        w_state_nxt    = r_state;
        bus.br_ready   = 1'b0;
        bus.resp_valid = 1'b0;
        w_br_accept    = 1'b0;
        w_eval         = 1'b0;
        case (r_state)
            S_IDLE: begin
                bus.br_ready = 1'b1;
                if (bus.br_valid && !bus.flush) begin
                    w_br_accept = 1'b1;
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.flush) begin
                    w_state_nxt = S_IDLE;
                end else if (w_cnt_zero && !bus.alu_valid) begin
                    w_eval      = 1'b1;
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                bus.resp_valid = 1'b1;
                w_state_nxt    = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cond     <= 3'b000;
            r_target   <= 16'h0000;
            r_pc_plus2 <= 16'h0000;
        end else if (w_br_accept) begin
            r_cond     <= bus.br_cond;
            r_target   <= bus.br_target;
            r_pc_plus2 <= bus.br_pc_plus2;
        end
    end

    branch_cond_eval u_cond_eval (
        .i_cond  (r_cond),
        .i_flags (r_flags),
        .o_taken (w_taken)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_resp_taken   <= 1'b0;
            r_resp_next_pc <= 16'h0000;
        end else if (w_eval) begin
            r_resp_taken   <= w_taken;
            r_resp_next_pc <= w_taken ? r_target : r_pc_plus2;
        end
    end

    assign bus.issue_ready   = w_issue_ready;
    assign bus.resp_taken    = r_resp_taken;
    assign bus.resp_next_pc  = r_resp_next_pc;
    assign bus.flags         = r_flags;
    assign bus.err_underflow = r_err_underflow;

endmodule

`default_nettype wire

// File: tb/tb_flag_branch_unit.sv
// ============================================================================
// Module   : tb_flag_branch_unit
// Brief    : Directed self-checking bench for flag_branch_unit.
// Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_flag_branch_unit;
    import flag_branch_unit_pkg::*;

    typedef struct packed {
        logic [2:0] cond;
        logic [7:0] taken_mask;   // bit index = {Z,V,N}
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;
    vec_t vecs [8];

    always #5 clk = ~clk;

    flag_branch_unit_if bus();

    flag_branch_unit #(.PEND_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_one();
        bus.flag_issue = 1'b1;
        step();
        bus.flag_issue = 1'b0;
    endtask

    task automatic retire(input opcode_t op, input logic [2:0] f);
        bus.alu_valid  = 1'b1;
        bus.alu_opcode = op;
        bus.alu_flags  = f;
        step();
        bus.alu_valid  = 1'b0;
    endtask

    task automatic branch(input logic [2:0] c, input logic [15:0] tgt, input logic [15:0] pc);
        bus.br_valid    = 1'b1;
        bus.br_cond     = c;
        bus.br_target   = tgt;
        bus.br_pc_plus2 = pc;
        step();
        bus.br_valid    = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".flags"},        32'(bus.flags),         32'h0);
        check({tag, ".issue_ready"},  32'(bus.issue_ready),   32'h1);
        check({tag, ".br_ready"},     32'(bus.br_ready),      32'h1);
        check({tag, ".resp_valid"},   32'(bus.resp_valid),    32'h0);
        check({tag, ".resp_taken"},   32'(bus.resp_taken),    32'h0);
        check({tag, ".resp_next_pc"}, 32'(bus.resp_next_pc),  32'h0);
        check({tag, ".err_underflow"},32'(bus.err_underflow), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] tgt;
        logic [15:0] pc;
        logic        exp_t;

        vecs[0] = '{3'd0, 8'h0F};  // NE
        vecs[1] = '{3'd1, 8'hF0};  // EQ
        vecs[2] = '{3'd2, 8'h05};  // GT
        vecs[3] = '{3'd3, 8'hAA};  // LT
        vecs[4] = '{3'd4, 8'hF5};  // GE
        vecs[5] = '{3'd5, 8'hFA};  // LE
        vecs[6] = '{3'd6, 8'hCC};  // OV
        vecs[7] = '{3'd7, 8'hFF};  // always

        bus.flag_issue  = 1'b0;
        bus.alu_valid   = 1'b0;
        bus.alu_opcode  = 3'd0;
        bus.alu_flags   = 3'd0;
        bus.br_valid    = 1'b0;
        bus.br_cond     = 3'd0;
        bus.br_target   = 16'h0;
        bus.br_pc_plus2 = 16'h0;
        bus.flush       = 1'b0;
        rst             = 1'b1;
        step();
        step();
        check_reset_outputs("reset");
        rst = 1'b0;
        step();

        // EQ taken after an ADD sets all flags; two-cycle latency
        issue_one();
        retire(OP_ADD, 3'b111);
        check("t1.flags", 32'(bus.flags), 32'h7);
        branch(3'b001, 16'h0040, 16'h0012);
        check("t1.br_ready_low", 32'(bus.br_ready), 32'h0);
        check("t1.no_early_resp", 32'(bus.resp_valid), 32'h0);
        step();
        check("t1.resp_valid", 32'(bus.resp_valid), 32'h1);
        check("t1.resp_taken", 32'(bus.resp_taken), 32'h1);
        check("t1.next_pc", 32'(bus.resp_next_pc), 32'h0040);
        step();
        check("t1.strobe_one_cycle", 32'(bus.resp_valid), 32'h0);
        check("t1.br_ready_back", 32'(bus.br_ready), 32'h1);
        check("t1.next_pc_hold", 32'(bus.resp_next_pc), 32'h0040);

        // XOR writes Z only; OV then not taken
        issue_one();
        retire(OP_ADD, 3'b000);
        check("t2.flags_clear", 32'(bus.flags), 32'h0);
        issue_one();
        retire(OP_XOR, 3'b111);
        check("t2.flags_xor", 32'(bus.flags), 32'h4);
        branch(3'b110, 16'h0080, 16'h0034);
        step();
        check("t2.resp_valid", 32'(bus.resp_valid), 32'h1);
        check("t2.resp_taken", 32'(bus.resp_taken), 32'h0);
        check("t2.next_pc", 32'(bus.resp_next_pc), 32'h0034);
        step();

        // Counter full; branch waits for the third retire and uses its flags
        bus.flag_issue = 1'b1;
        step();
        step();
        step();
        check("t3.issue_ready_full", 32'(bus.issue_ready), 32'h0);
        step();
        bus.flag_issue = 1'b0;
        check("t3.issue_ready_still_full", 32'(bus.issue_ready), 32'h0);
        branch(3'b011, 16'h0100, 16'h0050);
        step();
        step();
        check("t3.wait_no_resp", 32'(bus.resp_valid), 32'h0);
        check("t3.wait_br_ready", 32'(bus.br_ready), 32'h0);
        retire(OP_ADD, 3'b000);
        check("t3.issue_ready_after_retire", 32'(bus.issue_ready), 32'h1);
        step();
        retire(OP_ADD, 3'b000);
        check("t3.no_resp_two_left", 32'(bus.resp_valid), 32'h0);
        retire(OP_ADD, 3'b001);
        check("t3.no_resp_on_retire", 32'(bus.resp_valid), 32'h0);
        check("t3.flags_last", 32'(bus.flags), 32'h1);
        step();
        check("t3.resp_valid", 32'(bus.resp_valid), 32'h1);
        check("t3.resp_taken", 32'(bus.resp_taken), 32'h1);
        check("t3.next_pc", 32'(bus.resp_next_pc), 32'h0100);
        step();

        // Flush in WAIT drops the branch; counter untouched
        issue_one();
        branch(3'b111, 16'h0200, 16'h0300);
        step();
        check("t4.in_wait", 32'(bus.br_ready), 32'h0);
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        check("t4.br_ready_after_flush", 32'(bus.br_ready), 32'h1);
        check("t4.no_resp", 32'(bus.resp_valid), 32'h0);
        step();
        check("t4.no_resp_later", 32'(bus.resp_valid), 32'h0);
        bus.flush = 1'b1;
        branch(3'b111, 16'h0200, 16'h0300);
        bus.flush = 1'b0;
        check("t4.idle_flush_rejects", 32'(bus.br_ready), 32'h1);
        step();
        check("t4.idle_flush_no_resp", 32'(bus.resp_valid), 32'h0);
        branch(3'b111, 16'h0222, 16'h0333);
        step();
        step();
        check("t4.count_kept", 32'(bus.resp_valid), 32'h0);
        retire(OP_ADD, 3'b000);
        check("t4.no_resp_on_retire", 32'(bus.resp_valid), 32'h0);
        step();
        check("t4.resp_valid", 32'(bus.resp_valid), 32'h1);
        check("t4.next_pc", 32'(bus.resp_next_pc), 32'h0222);
        step();

        // All conditions against all flag combinations
        for (int c = 0; c < 8; c++) begin
            for (int f = 0; f < 8; f++) begin
                tgt   = 16'h1000 + 16'(c * 8 + f);
                pc    = 16'h2000 + 16'(c * 8 + f);
                exp_t = vecs[c].taken_mask[f];
                issue_one();
                retire(OP_ADD, 3'(f));
                branch(vecs[c].cond, tgt, pc);
                step();
                check($sformatf("tbl.c%0d.f%0d.valid", c, f), 32'(bus.resp_valid), 32'h1);
                check($sformatf("tbl.c%0d.f%0d.taken", c, f), 32'(bus.resp_taken), 32'(exp_t));
                check($sformatf("tbl.c%0d.f%0d.next_pc", c, f), 32'(bus.resp_next_pc),
                      32'(exp_t ? tgt : pc));
                step();
            end
        end

        // Orphan retire: sticky error, flags written, counter stays at 0
        check("t5.err_before", 32'(bus.err_underflow), 32'h0);
        retire(OP_SUB, 3'b010);
        check("t5.err_set", 32'(bus.err_underflow), 32'h1);
        check("t5.flags_written", 32'(bus.flags), 32'h2);
        check("t5.count_no_wrap", 32'(bus.issue_ready), 32'h1);
        step();
        step();
        step();
        check("t5.err_sticky", 32'(bus.err_underflow), 32'h1);

        // Async reset while a branch is waiting
        issue_one();
        branch(3'b111, 16'h0444, 16'h0555);
        step();
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("t6.async_rst");
        step();
        rst = 1'b0;
        step();
        check("t6.branch_dropped", 32'(bus.resp_valid), 32'h0);
        check("t6.br_ready", 32'(bus.br_ready), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/flag_branch_unit.md
# flag_branch_unit

Flag-register and branch-resolution block sitting directly downstream of the 16-bit ALU. It captures the ALU's Z/V/N flags under per-opcode write rules and tracks how many flag-writing ALU operations are still in flight. Branch requests are held until every older flag writer has retired; the unit then evaluates the 3-bit condition code and returns taken/not-taken plus the next PC.

## Interface
- PEND_W, 2, width of the in-flight counter; maximum outstanding ALU ops = 2^PEND_W − 1
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- flag_issue  in  1  one ALU op entered execute this cycle
- issue_ready  out  1  counter not full; flag_issue ignored when low
- alu_valid  in  1  ALU result/flags valid this cycle (retire)
- alu_opcode  in  3  opcode of retiring op (ADD=0, SUB=1, XOR=2, RED=3, SLL=4, SRA=5, ROR=6, PAD=7)
- alu_flags  in  3  [2]=Z, [1]=V, [0]=N from the ALU
- br_valid  in  1  branch request
- br_ready  out  1  request accepted when br_valid && br_ready
- br_cond  in  3  condition code
- br_target  in  16  taken address
- br_pc_plus2  in  16  fall-through address
- flush  in  1  abort any in-flight branch
- resp_valid  out  1  one-cycle response strobe
- resp_taken  out  1  branch decision
- resp_next_pc  out  16  br_target if taken else br_pc_plus2
- flags  out  3  current flag register {Z,V,N}
- err_underflow  out  1  sticky: alu_valid seen with counter 0

## Operation
- Flag write on alu_valid: ADD/SUB write Z, V, N; all other opcodes write Z only, V and N hold.
- Counter: +1 on accepted flag_issue, −1 on alu_valid, unchanged if both. alu_valid at count 0: no decrement, flags still written, err_underflow set.
- issue_ready = count < 2^PEND_W − 1.
- Conditions: 000 NE (!Z); 001 EQ (Z); 010 GT (!Z & !N); 011 LT (N); 100 GE (Z | !N); 101 LE (Z | N); 110 OV (V); 111 always.
- FSM states IDLE, WAIT, RESP.
  - IDLE: br_ready=1; on accept, capture cond/target/pc_plus2 → WAIT.
  - WAIT: when count==0 and alu_valid==0, evaluate against the flag register → RESP, with resp_* registered. Otherwise stay in WAIT.
  - RESP: resp_valid=1 for exactly one cycle → IDLE.
- flush: from WAIT → IDLE with no response. flush in RESP does not suppress the strobe already presented. Counter and flags are unaffected.
- br_valid and flush in the same IDLE cycle: the request is not accepted.

## Timing
- Reset values: flags=000, count=0, state IDLE, br_ready=1 (combinational from state), issue_ready=1, resp_valid=0, resp_taken=0, resp_next_pc=0, err_underflow=0.
- Reset mid-operation drops the captured branch silently.
- Minimum latency: accept at edge k, resp_valid high during the cycle after edge k+1 (2 cycles). br_ready low for ≥2 cycles per branch.
- Retire and evaluate never share an edge. A branch waiting on the last writer resolves at the edge after that writer's alu_valid and uses its flags.
- resp_taken and resp_next_pc hold their value after resp_valid falls, until the next response.

## Structure
- Shared package: opcode_t enum (ADD..PAD), br_cond_t enum (NE..UNC), flag bit index constants (Z=2, V=1, N=0).
- One sub-module: branch_cond_eval, purely combinational: cond + {Z,V,N} → taken.
- The rest is flat: counter, flag register, FSM, response registers.

## Test plan
- Reset; issue ADD, retire with alu_opcode=ADD, alu_flags=111; then branch cond=001, target=0x0040, pc_plus2=0x0012 → resp_taken=1, resp_next_pc=0x0040, 2 cycles after accept.
- Flags=000; retire XOR with alu_flags=111 → flags=100. Branch cond=110 (OV) → not taken, next_pc = pc_plus2.
- Issue 3 ops (PEND_W=2) → issue_ready=0. Branch accepted, stays in WAIT until the third alu_valid; resp_valid appears exactly one cycle after count reaches 0.
- Branch in WAIT, assert flush → no resp_valid, br_ready=1 next cycle. Count unchanged.
- alu_valid at count 0 → err_underflow=1 and stays 1 until rst. rst asserted mid-WAIT → all outputs return to reset values immediately.
- All 8 conditions against all 8 flag combinations → resp_taken matches the condition table.
